switch_allocator: RTL and testbench
===================================

# switch_allocator

Per-output wormhole switch allocator for the 5-port NoC router. Each cycle it arbitrates, per output port, among input-buffer heads requesting that output, and drives the crossbar's per-output grant/select plus a pop strobe back to each input buffer. A granted output stays locked to its winning input from head flit through tail flit; fairness between packets is round-robin, and a grant is issued only when the downstream credit is available.

## Interface
- FLIT_WIDTH, 76: flit width; carried for package consistency, no datapath here.
- PORT_NUM, 5: number of router ports (inputs = outputs).
- PW, $clog2(PORT_NUM): port index width (3 at default).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; asserting low clears all state immediately.
- req_valid  in  [PORT_NUM]  input i has a flit at its buffer head.
- req_port  in  [PORT_NUM][PW]  requested output index for input i's head flit.
- req_head  in  [PORT_NUM]  input i's head flit is a head flit.
- req_tail  in  [PORT_NUM]  input i's head flit is a tail flit (head+tail = single-flit packet).
- credit_avail  in  [PORT_NUM]  output o has at least one downstream credit this cycle.
- grant  out  [PORT_NUM]  output o carries a flit this cycle (crossbar per-output enable).
- sel  out  [PORT_NUM][PW]  input index routed to output o; 0 when grant[o]=0.
- in_pop  out  [PORT_NUM]  input i's head flit is consumed this cycle.

## Operation
- Per output o: FSM {IDLE, LOCKED}, owner register (PW bits), round-robin pointer rr_ptr (PW bits).
- Eligibility, IDLE: input i eligible iff req_valid[i] && req_head[i] && req_port[i]==o.
- Eligibility, LOCKED: only owner eligible, iff req_valid[owner] && req_port[owner]==o.
- Arbitration: first eligible input scanning rr_ptr, rr_ptr+1, ... modulo PORT_NUM.
- grant[o]=1 iff an eligible input exists and credit_avail[o]=1. sel[o]=winner; in_pop[winner]=1.
- An input requests exactly one output, so in_pop[i] is the OR over outputs of (grant[o] && sel[o]==i).
- IDLE + grant, winner not tail: -> LOCKED, owner=winner.
- IDLE + grant, winner tail (single-flit): stay IDLE.
- LOCKED + grant of tail flit: -> IDLE.
- rr_ptr[o] advances to (winner+1) mod PORT_NUM on every packet-ending grant (a tail flit); it is unchanged otherwise.
- No credit: no grant, no pop, state and pointer unchanged, lock held.
- Owner not valid while LOCKED (bubble): no grant, lock held.
- req_port >= PORT_NUM: the request is never eligible for any output.
- Non-head flits from non-owners are never eligible; body flits are never granted in IDLE.

## Timing
- grant, sel and in_pop are combinational from the current state plus the inputs: zero-cycle allocation. The buffer pops and the crossbar transfers in the same cycle.
- FSM, owner and rr_ptr update at the rising edge after a grant. The next packet's head can win on the cycle after a tail grant.
- Reset (rst=0): all FSMs IDLE, owner=0, rr_ptr=0. grant, sel and in_pop are forced to 0 while rst=0, independent of the inputs.
- Reset asserted mid-packet drops all locks. Any remaining body flits then become ineligible, which is upstream's responsibility.
- Different outputs allocate independently in the same cycle. Up to PORT_NUM grants per cycle.

## Structure
- noc_pkg holds: PORT_NUM, FLIT_WIDTH, port index typedef port_idx_t, and enum port_id_e {LOCAL=0, NORTH, EAST, SOUTH, WEST}. It is shared with the crossbar and input buffers.
- The per-output lock FSM states also live in noc_pkg as alloc_state_e {IDLE, LOCKED}.
- One sub-module: rr_arbiter (PORT_NUM request bits, ptr in, one-hot grant + index out, purely combinational). It is instantiated once per output. Lock FSMs and pointers stay in switch_allocator.

## Test plan
- Reset: hold rst=0 with all req_valid=1 -> grant=0, in_pop=0, sel=0. Release -> the first grant goes to the lowest-index eligible input (rr_ptr=0).
- Contention: inputs 1 and 3 send single-flit packets (head+tail) to output 2 with credit held high -> winners 1,3,1,3 on consecutive cycles. rr_ptr[2] = 2,4,2,4.
- Wormhole lock: input 0 sends head/body/body/tail to output 4 while input 2 sends a head to output 4 -> output 4 grants input 0 for 4 cycles. Input 2 wins in cycle 5.
- Credit stall: mid-packet, credit_avail[1]=0 for 3 cycles -> grant[1]=0, in_pop=0, lock held. Resume on the same owner with no reordering.
- Parallel + invalid: inputs 0->1, 1->2, 2->3, 3->4, 4->0 all with credit -> 5 grants in one cycle. req_port=7 on input 3 -> input 3 is never popped.
- Reset mid-packet: assert rst during LOCKED -> all outputs go IDLE and rr_ptr=0. A later body flit from the old owner is not granted.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, flit width, port indices and
// the per-output lock states used by the switch allocator.
package noc_pkg;

  localparam int unsigned PORT_NUM   = 5;
  localparam int unsigned FLIT_WIDTH = 76;
  localparam int unsigned PW         = $clog2(PORT_NUM);

  typedef logic [PW-1:0] port_idx_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_id_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  // Successor of a port index, wrapping at PORT_NUM.
  function automatic port_idx_t rr_next(input port_idx_t idx);
    return (idx == port_idx_t'(PORT_NUM - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request bit found scanning
// from i_ptr upward, wrapping modulo PORT_NUM.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [PORT_NUM-1:0] i_req,
  input  port_idx_t           i_ptr,
  output logic [PORT_NUM-1:0] o_gnt,
  output port_idx_t           o_idx,
  output logic                o_valid
);

  port_idx_t w_j;

  // Priority scan starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < PORT_NUM; k++) begin
      w_j = port_idx_t'((32'(i_ptr) + k) % PORT_NUM);
      if (!o_valid && i_req[w_j]) begin
        o_valid    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator. Each output locks onto the input
// that won its head flit until that packet's tail is granted; packets are
// served round-robin and only when a downstream credit is available.
module switch_allocator
  import noc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORT_NUM-1:0]          req_valid,
  input  logic [PORT_NUM-1:0][PW-1:0]  req_port,
  input  logic [PORT_NUM-1:0]          req_head,
  input  logic [PORT_NUM-1:0]          req_tail,
  input  logic [PORT_NUM-1:0]          credit_avail,
  output logic [PORT_NUM-1:0]          grant,
  output logic [PORT_NUM-1:0][PW-1:0]  sel,
  output logic [PORT_NUM-1:0]          in_pop
);

  // Row o holds the one-hot input popped by output o (zero when no grant).
  logic [PORT_NUM-1:0][PORT_NUM-1:0] w_pop_mat;

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    alloc_state_e        r_state;
    port_idx_t           r_owner;
    port_idx_t           r_rr_ptr;
    logic [PORT_NUM-1:0] w_elig;
    logic [PORT_NUM-1:0] w_gnt_oh;
    port_idx_t           w_win;
    logic                w_any;
    logic                w_grant;
    logic                w_win_tail;
    logic                w_match;

    // Eligibility: any head flit for this output when idle, only the
    // owner's flits while locked. Out-of-range ports never match.
    always_comb begin
      w_elig  = '0;
      w_match = 1'b0;
      for (int i = 0; i < PORT_NUM; i++) begin
        w_match = req_valid[i] && (req_port[i] == port_idx_t'(o));
        if (r_state == LOCKED) begin
          w_elig[i] = w_match && (port_idx_t'(i) == r_owner);
        end else begin
          w_elig[i] = w_match && req_head[i];
        end
      end
    end

    rr_arbiter u_arb (
      .i_req   (w_elig),
      .i_ptr   (r_rr_ptr),
      .o_gnt   (w_gnt_oh),
      .o_idx   (w_win),
      .o_valid (w_any)
    );

    // Outputs are held quiet while reset is asserted.
    assign w_grant    = rst && w_any && credit_avail[o];
    assign w_win_tail = req_tail[w_win];

    assign grant[o]     = w_grant;
    assign sel[o]       = w_grant ? w_win : '0;
    assign w_pop_mat[o] = w_grant ? w_gnt_oh : '0;

    // Lock FSM, owner and round-robin pointer advance only on a grant.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state  <= IDLE;
        r_owner  <= '0;
        r_rr_ptr <= '0;
      end else if (w_grant) begin
        if (w_win_tail) begin
          r_state  <= IDLE;
          r_rr_ptr <= rr_next(w_win);
        end else if (r_state == IDLE) begin
          r_state <= LOCKED;
          r_owner <= w_win;
        end
      end
    end
  end

  // Each input targets one output, so OR-ing the per-output rows is safe.
  always_comb begin
    in_pop = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      in_pop = in_pop | w_pop_mat[o];
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: the driver pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares.
module tb_switch_allocator;

  logic        clk;
  logic        rst;
  logic [4:0]  req_valid;
  logic [4:0][2:0] req_port;
  logic [4:0]  req_head;
  logic [4:0]  req_tail;
  logic [4:0]  credit_avail;
  logic [4:0]  grant;
  logic [4:0][2:0] sel;
  logic [4:0]  in_pop;

  typedef struct {
    logic [4:0]  g;
    logic [14:0] s;
    logic [4:0]  p;
    int          id;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;

  switch_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_port     (req_port),
    .req_head     (req_head),
    .req_tail     (req_tail),
    .credit_avail (credit_avail),
    .grant        (grant),
    .sel          (sel),
    .in_pop       (in_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack five 3-bit indices, element 0 in the low bits.
  function automatic logic [14:0] pp(input int a, input int b, input int c,
                                     input int d, input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic step(input logic r, input logic [4:0] v, input logic [14:0] p,
                      input logic [4:0] h, input logic [4:0] t, input logic [4:0] c,
                      input logic [4:0] eg, input logic [14:0] es, input logic [4:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    req_valid    = v;
    req_port     = p;
    req_head     = h;
    req_tail     = t;
    credit_avail = c;
    e.g  = eg;
    e.s  = es;
    e.p  = ep;
    e.id = vec_id;
    vec_id++;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (grant !== e.g) begin
        errors++;
        $display("FAIL grant vec=%0d actual=%b required=%b", e.id, grant, e.g);
      end
      checks++;
      if (sel !== e.s) begin
        errors++;
        $display("FAIL sel vec=%0d actual=%h required=%h", e.id, sel, e.s);
      end
      checks++;
      if (in_pop !== e.p) begin
        errors++;
        $display("FAIL in_pop vec=%0d actual=%b required=%b", e.id, in_pop, e.p);
      end
    end
  end

  initial begin
    rst          = 1'b0;
    req_valid    = '0;
    req_port     = '0;
    req_head     = '0;
    req_tail     = '0;
    credit_avail = '0;

    // Reset holds every output low despite live requests.
    repeat (2) step(1'b0, 5'b11111, pp(0,1,2,3,4), 5'b11111, 5'b11111, 5'b11111,
                    5'b00000, pp(0,0,0,0,0), 5'b00000);
    // Release: lowest eligible wins, then pointer moves past it.
    step(1'b1, 5'b10100, pp(0,0,0,0,0), 5'b10100, 5'b10100, 5'b11111,
         5'b00001, pp(2,0,0,0,0), 5'b00100);
    step(1'b1, 5'b10100, pp(0,0,0,0,0), 5'b10100, 5'b10100, 5'b11111,
         5'b00001, pp(4,0,0,0,0), 5'b10000);

    // Contention on output 2: winners alternate 1,3,1,3.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 5'b01010, pp(0,2,0,2,0), 5'b01010, 5'b01010, 5'b11111,
           5'b00100, (k % 2 == 0) ? pp(0,0,1,0,0) : pp(0,0,3,0,0),
           (k % 2 == 0) ? 5'b00010 : 5'b01000);
    end

    // Wormhole lock: input 0 holds output 4 for four flits, then input 2.
    step(1'b1, 5'b00101, pp(4,0,4,0,0), 5'b00101, 5'b00100, 5'b11111,
         5'b10000, pp(0,0,0,0,0), 5'b00001);
    repeat (2) step(1'b1, 5'b00101, pp(4,0,4,0,0), 5'b00100, 5'b00100, 5'b11111,
                    5'b10000, pp(0,0,0,0,0), 5'b00001);
    step(1'b1, 5'b00101, pp(4,0,4,0,0), 5'b00100, 5'b00101, 5'b11111,
         5'b10000, pp(0,0,0,0,0), 5'b00001);
    step(1'b1, 5'b00100, pp(4,0,4,0,0), 5'b00100, 5'b00100, 5'b11111,
         5'b10000, pp(0,0,0,0,2), 5'b00100);

    // Credit stall on output 1 with a competing head from input 4.
    step(1'b1, 5'b01000, pp(0,0,0,1,1), 5'b01000, 5'b00000, 5'b11111,
         5'b00010, pp(0,3,0,0,0), 5'b01000);
    repeat (3) step(1'b1, 5'b11000, pp(0,0,0,1,1), 5'b10000, 5'b10000, 5'b11101,
                    5'b00000, pp(0,0,0,0,0), 5'b00000);
    step(1'b1, 5'b11000, pp(0,0,0,1,1), 5'b10000, 5'b10000, 5'b11111,
         5'b00010, pp(0,3,0,0,0), 5'b01000);
    // Bubble: owner not valid, lock still excludes input 4.
    step(1'b1, 5'b10000, pp(0,0,0,1,1), 5'b10000, 5'b10000, 5'b11111,
         5'b00000, pp(0,0,0,0,0), 5'b00000);
    step(1'b1, 5'b11000, pp(0,0,0,1,1), 5'b10000, 5'b11000, 5'b11111,
         5'b00010, pp(0,3,0,0,0), 5'b01000);
    step(1'b1, 5'b10000, pp(0,0,0,1,1), 5'b10000, 5'b10000, 5'b11111,
         5'b00010, pp(0,4,0,0,0), 5'b10000);

    // Five independent grants in one cycle.
    step(1'b1, 5'b11111, pp(1,2,3,4,0), 5'b11111, 5'b11111, 5'b11111,
         5'b11111, pp(4,0,1,2,3), 5'b11111);
    // Input 3 out of range, input 1 body flit to an idle output.
    step(1'b1, 5'b11111, pp(1,2,3,7,0), 5'b11101, 5'b11101, 5'b11111,
         5'b01011, pp(4,0,0,2,0), 5'b10101);

    // Reset mid-packet: lock on output 3 dropped, body flit then ignored.
    step(1'b1, 5'b00100, pp(0,0,3,0,0), 5'b00100, 5'b00000, 5'b11111,
         5'b01000, pp(0,0,0,2,0), 5'b00100);
    step(1'b0, 5'b00100, pp(0,0,3,0,0), 5'b00000, 5'b00000, 5'b11111,
         5'b00000, pp(0,0,0,0,0), 5'b00000);
    step(1'b1, 5'b00100, pp(0,0,3,0,0), 5'b00000, 5'b00000, 5'b11111,
         5'b00000, pp(0,0,0,0,0), 5'b00000);
    // Pointer of output 2 back at 0: input 1 beats input 3.
    step(1'b1, 5'b01010, pp(0,2,0,2,0), 5'b01010, 5'b01010, 5'b11111,
         5'b00100, pp(0,0,1,0,0), 5'b00010);

    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
